// File: rtl/fifo_byte_packer.sv
// Pops lane-wide entries from a synchronous FIFO, packs PACK of them into one
// word (lane 0 in the LSBs) and hands the word downstream over valid/ready.
module fifo_byte_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  localparam int CW        = $clog2(PACK + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_fifo_empty,
  input  logic                       i_fifo_valid,
  input  logic [DATA_WIDTH-1:0]      i_fifo_rdata,
  output logic                       o_fifo_ren,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [DATA_WIDTH*PACK-1:0] o_data,
  output logic [CW-1:0]              o_count,
  output logic                       o_busy,
  output logic                       dbg_state
);

  // Handshake: a word moves on any rising edge where o_valid & i_ready; o_valid
  // never drops and o_data/o_count never change while a word waits for i_ready.

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  state_t                             state;
  logic [CW-1:0]                      acc_cnt_r;
  logic                               pend_r;
  logic [PACK-1:0][DATA_WIDTH-1:0]    acc_r;

  logic land;
  logic slot_free;
  logic xfer_full;
  logic flush_done;
  logic xfer_part;
  logic xfer;
  logic room;

  assign land       = i_fifo_valid & pend_r;
  assign slot_free  = ~o_valid | i_ready;
  assign xfer_full  = (acc_cnt_r == PACK_C) & slot_free;
  // No read in flight means nothing can land, so the accumulator is final.
  assign flush_done = (state == FLUSH) & ~pend_r;
  assign xfer_part  = flush_done & (acc_cnt_r != '0) & slot_free;
  assign xfer       = xfer_full | xfer_part;
  assign room       = ({1'b0, acc_cnt_r} + {{CW{1'b0}}, pend_r}) < {1'b0, PACK_C};

  assign o_fifo_ren = ~i_reset & ~i_fifo_empty & (state == RUN) & ~i_flush &
                      (room | xfer_full);

  assign o_busy    = (acc_cnt_r != '0) | pend_r | o_valid | (state == FLUSH);
  assign dbg_state = state;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= RUN;
      acc_cnt_r <= '0;
      pend_r    <= 1'b0;
      acc_r     <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_count   <= '0;
    end else begin
      pend_r <= o_fifo_ren;

      // A transfer and a land are mutually exclusive: both transfer kinds
      // imply no read is in flight.
      if (xfer) begin
        o_data    <= acc_r;
        o_count   <= acc_cnt_r;
        o_valid   <= 1'b1;
        acc_r     <= '0;
        acc_cnt_r <= '0;
      end else begin
        if (i_ready) o_valid <= 1'b0;
        if (land) begin
          for (int i = 0; i < PACK; i++) begin
            if (acc_cnt_r == CW'(i)) acc_r[i] <= i_fifo_rdata;
          end
          acc_cnt_r <= acc_cnt_r + CW'(1);
        end
      end

      case (state)
        RUN:     if (i_flush) state <= FLUSH;
        FLUSH:   if (flush_done && (acc_cnt_r == '0 || slot_free)) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Bench for fifo_byte_packer: FIFO model, table vectors, directed corner
// sequences and a randomized stream checked against a byte-chunking model.
module tb_fifo_byte_packer;
  localparam int DW   = 8;
  localparam int PACK = 4;
  localparam int CW   = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           fifo_empty = 1'b1;
  logic           fifo_valid;
  logic [DW-1:0]  fifo_rdata;
  logic           fifo_ren;
  logic           flush;
  logic           valid;
  logic           ready;
  logic [31:0]    data;
  logic [CW-1:0]  count;
  logic           busy;
  logic           dbg_state;

  always #5 clk = ~clk;

  fifo_byte_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_fifo_empty(fifo_empty), .i_fifo_valid(fifo_valid), .i_fifo_rdata(fifo_rdata),
    .o_fifo_ren(fifo_ren), .i_flush(flush),
    .o_valid(valid), .i_ready(ready), .o_data(data), .o_count(count),
    .o_busy(busy), .dbg_state(dbg_state)
  );

  // Synchronous FIFO model: data returns one cycle after an accepted read.
  logic [DW-1:0] fifo_q[$];
  int            ren_cnt = 0;

  always @(posedge clk or posedge reset) begin
    logic [DW-1:0] b;
    if (reset) begin
      fifo_valid <= 1'b0;
      fifo_rdata <= '0;
    end else begin
      fifo_valid <= fifo_ren;
      if (fifo_ren) begin
        ren_cnt = ren_cnt + 1;
        if (fifo_q.size() > 0) begin
          b = fifo_q.pop_front();
          fifo_rdata <= b;
        end
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rand_ready = 0;
  logic [34:0]   exp_q[$];
  logic [DW-1:0] model_bytes[$];
  logic          hold_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One cycle: inputs are already set; score the handshake that the coming edge completes.
  task automatic tick();
    logic [34:0] e;
    if (rand_ready != 0) ready = ($urandom_range(0, 3) != 0);
    if (hold_valid) check("hold_valid", valid, 1);
    if (fifo_ren) check("ren_when_empty", fifo_empty, 0);
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h count %0d, expected no word", data, count);
      end else begin
        e = exp_q.pop_front();
        check("word_data", data, e[31:0]);
        check("word_count", count, e[34:32]);
      end
    end
    hold_valid = valid && !ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic raw_push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Reference: the byte stream cut into PACK-byte chunks, cut early at flushes.
  task automatic model_emit();
    logic [34:0] w;
    w = '0;
    for (int i = 0; i < model_bytes.size(); i++) w[8*i +: 8] = model_bytes[i];
    w[34:32] = 3'(model_bytes.size());
    exp_q.push_back(w);
    model_bytes.delete();
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    raw_push(b);
    model_bytes.push_back(b);
    if (model_bytes.size() == PACK) model_emit();
  endtask

  task automatic model_flush();
    if (model_bytes.size() > 0) model_emit();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_words_left", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic wait_fifo_empty(input int budget);
    int n = 0;
    while (fifo_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("fifo_drain_left", 64'(fifo_q.size()), 0);
    tick();
    tick();
  endtask

  task automatic flush_seq();
    wait_fifo_empty(300);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
  endtask

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        do_flush;
    logic [31:0] exp_data;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0;
    logic [31:0] vb;
    vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 3'd4};
    vecs[1] = '{3, 32'h00CCBBAA, 1'b1, 32'h00CCBBAA, 3'd3};
    vecs[2] = '{4, 32'hDDC0FFEE, 1'b0, 32'hDDC0FFEE, 3'd4};
    vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 3'd1};
    vecs[4] = '{2, 32'h00007E81, 1'b1, 32'h00007E81, 3'd2};
    vecs[5] = '{4, 32'h00FF00FF, 1'b0, 32'h00FF00FF, 3'd4};

    reset = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    #1;
    check("reset_valid", valid, 0);
    check("reset_data", data, 0);
    check("reset_count", count, 0);
    check("reset_busy", busy, 0);
    check("reset_ren", fifo_ren, 0);
    check("reset_state", dbg_state, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors, downstream always ready.
    ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      r0 = ren_cnt;
      vb = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++) raw_push(vb[8*i +: 8]);
      exp_q.push_back({vecs[v].exp_count, vecs[v].exp_data});
      if (vecs[v].do_flush) begin
        wait_fifo_empty(50);
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      wait_drain(50);
      for (int i = 0; i < 3; i++) tick();
      check("vec_ren_cycles", 64'(ren_cnt - r0), 64'(vecs[v].n));
    end

    // Flush with nothing accumulated: one FLUSH cycle, no word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush_state", dbg_state, 1);
    check("empty_flush_busy", busy, 1);
    tick();
    check("empty_flush_exit", dbg_state, 0);
    check("empty_flush_valid", valid, 0);

    // Back-pressure: 12 bytes with downstream stalled.
    ready = 1'b0;
    r0 = ren_cnt;
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    for (int i = 0; i < 20; i++) tick();
    check("stall_valid", valid, 1);
    check("stall_data", data, 32'h04030201);
    check("stall_count", count, 4);
    check("stall_ren", fifo_ren, 0);
    check("stall_fifo_left", 64'(fifo_q.size()), 4);
    check("stall_ren_cycles", 64'(ren_cnt - r0), 8);
    ready = 1'b1;
    wait_drain(60);

    // Flush the cycle after a read: the in-flight byte joins the partial word.
    push_byte(8'hC1);
    wait_fifo_empty(20);
    push_byte(8'hDD);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_flush();
    wait_drain(20);

    // Reset with two lanes held, then a clean full word.
    raw_push(8'h99);
    raw_push(8'h98);
    wait_fifo_empty(20);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    raw_push(8'h55);
    #1;
    check("mid_reset_valid", valid, 0);
    check("mid_reset_data", data, 0);
    check("mid_reset_count", count, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_ren", fifo_ren, 0);
    fifo_q.delete();
    fifo_empty = 1'b1;
    hold_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_byte(8'hA1 + 8'(i));
    wait_drain(30);

    // Randomized stream with random back-pressure and occasional flushes.
    rand_ready = 1;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) push_byte(8'($urandom_range(0, 255)));
      if (it % 45 == 44) flush_seq();
      tick();
    end
    flush_seq();
    rand_ready = 0;
    ready = 1'b1;
    wait_drain(300);
    tick();
    tick();
    check("end_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
